// File: rtl/b32_seq_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Valid/ready on both sides; a zero divisor short-circuits straight to DONE.
module b32_seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_INC = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH:0]   rem_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign in_ready = (state == IDLE);

    // Trial subtraction as X + ~Y + 1; the extra MSB is the borrow.
    always_comb begin
        shifted = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        trial   = shifted + ~{1'b0, dsr_r} + ONE;
        borrow  = trial[WIDTH];
        rem_nxt = borrow ? shifted : trial;
        quo_nxt = {quo_r[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            quo_r       <= '0;
            dsr_r       <= '0;
            rem_r       <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quo_r <= dividend;
                            rem_r <= '0;
                            dsr_r <= divisor;
                            cnt   <= '0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt   <= cnt + CNT_INC;
                    if (cnt == LAST) begin
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
